// File: rtl/spi_slave_regif.sv
// spi_slave_regif: SPI mode-0 target that decodes CMD / ADDR / DATA frames
// (MSB first) into single-cycle register read/write strobes. All SPI pins are
// oversampled on clk_i; writes auto-increment, reads prefetch the next word.
module spi_slave_regif #(
    parameter int unsigned      CMD_W  = 8,
    parameter int unsigned      ADDR_W = 8,
    parameter int unsigned      DATA_W = 16,
    parameter logic [CMD_W-1:0] WR_CMD = 8'h0A,
    parameter logic [CMD_W-1:0] RD_CMD = 8'h0B
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spi_clk_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_sdi_i,
    output logic              spi_sdo_o,
    output logic              spi_sdo_oe_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              reg_we_o,
    output logic              reg_re_o,
    input  logic [DATA_W-1:0] reg_rdata_i,
    output logic              busy_o
);

    localparam int unsigned MaxAc = (CMD_W > ADDR_W) ? CMD_W : ADDR_W;
    localparam int unsigned MaxW  = (MaxAc > DATA_W) ? MaxAc : DATA_W;
    localparam int unsigned CntW  = $clog2(MaxW) + 1;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StCmd   = 3'd1;
    localparam logic [2:0] StAddr  = 3'd2;
    localparam logic [2:0] StWdata = 3'd3;
    localparam logic [2:0] StRdata = 3'd4;
    localparam logic [2:0] StDrop  = 3'd5;

    // Synchroniser chains; the third stage only serves edge detection.
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic cs_s1_q, cs_s2_q, cs_s3_q;
    logic sdi_s1_q, sdi_s2_q;
    // Set once CS has been seen high after reset, so a select that is already
    // low when reset releases never opens a frame.
    logic armed_q;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [2:0]        state_q, state_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [MaxW-2:0]   rx_q, rx_d;
    logic [MaxW-1:0]   rx_shift;
    logic              is_rd_q, is_rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              ld_q, ld_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_vld_q, buf_vld_d;
    logic              first_q, first_d;

    // Two-flop synchronisers plus edge-detect history for SCLK and CS.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            cs_s1_q   <= 1'b0;
            cs_s2_q   <= 1'b0;
            cs_s3_q   <= 1'b0;
            sdi_s1_q  <= 1'b0;
            sdi_s2_q  <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            sclk_s1_q <= spi_clk_i;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            cs_s1_q   <= spi_cs_n_i;
            cs_s2_q   <= cs_s1_q;
            cs_s3_q   <= cs_s2_q;
            sdi_s1_q  <= spi_sdi_i;
            sdi_s2_q  <= sdi_s1_q;
            armed_q   <= armed_q | cs_s2_q;
        end
    end

    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
    assign cs_rise   = cs_s2_q & ~cs_s3_q;
    // cs_s3_q high implies armed_q already set, so no extra qualification.
    assign cs_fall   = ~cs_s2_q & cs_s3_q;

    assign rx_shift = {rx_q, sdi_s2_q};

    // Frame decode: next-state for the FSM, shifters, address and strobes.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        is_rd_d   = is_rd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        ld_d      = re_q;
        tx_d      = tx_q;
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;
        first_d   = first_q;

        // Address advances in the cycle after the write strobe.
        if (we_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        // Read data arrives the cycle after reg_re_o. The first word goes
        // straight to the shifter; prefetched words wait for the word-boundary fall.
        if (ld_q && state_q == StRdata) begin
            if (first_q) begin
                tx_d    = reg_rdata_i;
                first_d = 1'b0;
            end else begin
                buf_d     = reg_rdata_i;
                buf_vld_d = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d   = StCmd;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                end
            end
            StCmd: begin
                if (sclk_rise) begin
                    rx_d = rx_shift[MaxW-2:0];
                    if (bit_cnt_q == CntW'(CMD_W - 1)) begin
                        bit_cnt_d = '0;
                        if (rx_shift[CMD_W-1:0] == WR_CMD) begin
                            is_rd_d = 1'b0;
                            state_d = StAddr;
                        end else if (rx_shift[CMD_W-1:0] == RD_CMD) begin
                            is_rd_d = 1'b1;
                            state_d = StAddr;
                        end else begin
                            state_d = StDrop;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end
            end
            StAddr: begin
                if (sclk_rise) begin
                    rx_d = rx_shift[MaxW-2:0];
                    if (bit_cnt_q == CntW'(ADDR_W - 1)) begin
                        bit_cnt_d = '0;
                        addr_d    = rx_shift[ADDR_W-1:0];
                        if (is_rd_q) begin
                            state_d   = StRdata;
                            re_d      = 1'b1;
                            first_d   = 1'b1;
                            buf_vld_d = 1'b0;
                            tx_d      = '0;
                        end else begin
                            state_d = StWdata;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end
            end
            StWdata: begin
                if (sclk_rise) begin
                    rx_d = rx_shift[MaxW-2:0];
                    if (bit_cnt_q == CntW'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        wdata_d   = rx_shift[DATA_W-1:0];
                        we_d      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end
            end
            StRdata: begin
                if (sclk_rise) begin
                    if (bit_cnt_q == CntW'(DATA_W - 1)) begin
                        // Last bit of the word sampled: prefetch the next one.
                        bit_cnt_d = '0;
                        addr_d    = addr_q + ADDR_W'(1);
                        re_d      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q != '0) begin
                        tx_d = {tx_q[DATA_W-2:0], 1'b0};
                    end else if (buf_vld_q) begin
                        tx_d      = buf_q;
                        buf_vld_d = 1'b0;
                    end
                end
            end
            StDrop: begin
                state_d = StDrop;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // CS deassertion ends the frame from any state; partial words are lost.
        if (cs_rise) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            buf_vld_d = 1'b0;
            first_d   = 1'b0;
            we_d      = 1'b0;
            re_d      = 1'b0;
        end
    end

    // Frame state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            is_rd_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            ld_q      <= 1'b0;
            tx_q      <= '0;
            buf_q     <= '0;
            buf_vld_q <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            is_rd_q   <= is_rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
            ld_q      <= ld_d;
            tx_q      <= tx_d;
            buf_q     <= buf_d;
            buf_vld_q <= buf_vld_d;
            first_q   <= first_d;
        end
    end

    assign spi_sdo_oe_o = (state_q == StRdata);
    assign spi_sdo_o    = spi_sdo_oe_o & tx_q[DATA_W-1];
    assign reg_addr_o   = addr_q;
    assign reg_wdata_o  = wdata_q;
    assign reg_we_o     = we_q;
    assign reg_re_o     = re_q;
    assign busy_o       = armed_q & ~cs_s2_q;

endmodule
